led_step_decoder: RTL and testbench

//  Receive-side monitor for the 10-LED one-hot stepping bus. Registers the LED

---
 rtl/led_step_decoder_if.sv | 42 ++++
 rtl/led_step_decoder.sv | 161 ++++++++++++++++
 tb/tb_led_step_decoder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_step_decoder_if.sv
// ---------------------------------------------------------------------------
// led_step_decoder_if
// Bundles the observed LED bus and the monitor's status outputs.
//   master : the side that owns led_in (LED driver / testbench)
//   slave  : the led_step_decoder monitor, which owns all status outputs
// Signals:
//   led_in      one-hot LED bus under observation
//   idx_out     decoded index of the lit LED
//   valid       registered LED vector is exactly one-hot
//   step_pulse  one-cycle pulse per accepted index change
//   step_count  number of accepted steps (wraps)
//   dwell_last  length of the previous dwell in clk cycles (saturating)
//   seq_err     sticky: a step was not +1 mod N_LEDS
//   time_err    sticky: a checked dwell was outside tolerance
//   onehot_err  sticky: LED vector was zero or had several bits set
// ---------------------------------------------------------------------------
interface led_step_decoder_if #(
  parameter int N_LEDS = 10,
  parameter int IDX_W  = 4
);
  logic [N_LEDS-1:0] led_in;
  logic [IDX_W-1:0]  idx_out;
  logic              valid;
  logic              step_pulse;
  logic [15:0]       step_count;
  logic [31:0]       dwell_last;
  logic              seq_err;
  logic              time_err;
  logic              onehot_err;

  modport master (
    output led_in,
    input  idx_out, valid, step_pulse, step_count, dwell_last,
           seq_err, time_err, onehot_err
  );

  modport slave (
    input  led_in,
    output idx_out, valid, step_pulse, step_count, dwell_last,
           seq_err, time_err, onehot_err
  );
endinterface

// File: rtl/led_step_decoder.sv
// ---------------------------------------------------------------------------
// led_step_decoder
// Receive-side monitor for a one-hot stepping LED bus. The LED vector is
// registered, decoded to a binary index and every index change is checked for
// a +1 (mod N_LEDS) advance and a dwell of EXPECT_CYCLES +/- TOL_CYCLES.
// Ports:
//   clk  : system clock, all logic on posedge
//   rst  : synchronous reset, active-high, overrides everything
//   bus  : led_step_decoder_if.slave (led_in in, status outputs out)
// Outputs appear two clocks after led_in (register stage + decode stage).
// ---------------------------------------------------------------------------
module led_step_decoder #(
  parameter int          N_LEDS        = 10,
  parameter int          IDX_W         = 4,
  parameter int unsigned EXPECT_CYCLES = 50000001,
  parameter int unsigned TOL_CYCLES    = 2
) (
  input logic               clk,
  input logic               rst,
  led_step_decoder_if.slave bus
);

  localparam logic [31:0] DWELL_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_ACQ,
    ST_TRACK
  } state_e;

  state_e state_q, state_d;

  logic [N_LEDS-1:0] led_q, led_d;
  logic              primed_q, primed_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              step_pulse_q, step_pulse_d;
  logic [15:0]       step_count_q, step_count_d;
  logic [31:0]       dwell_last_q, dwell_last_d;
  logic [31:0]       dwell_q, dwell_d;
  logic              first_dwell_q, first_dwell_d;
  logic              seq_err_q, seq_err_d;
  logic              time_err_q, time_err_d;
  logic              onehot_err_q, onehot_err_d;

  logic              legal;
  logic [IDX_W-1:0]  idx_new;
  logic [IDX_W-1:0]  idx_succ;
  logic              same_idx;
  logic              dwell_bad;
  logic signed [32:0] dwell_diff;
  logic signed [32:0] dwell_abs;

  // Decode of the registered LED vector. A vector is one-hot when it is
  // non-zero and clearing its lowest set bit leaves nothing behind.
  // The dwell difference is taken in 33-bit signed form so it never wraps.
  always_comb begin
    legal    = (led_q != '0) && ((led_q & (led_q - N_LEDS'(1))) == '0);
    idx_new  = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (led_q[i]) idx_new = IDX_W'(i);
    end
    idx_succ   = (idx_q == IDX_W'(N_LEDS - 1)) ? '0 : idx_q + IDX_W'(1);
    same_idx   = (idx_new == idx_q);
    dwell_diff = $signed({1'b0, dwell_q}) - $signed({1'b0, EXPECT_CYCLES});
    dwell_abs  = dwell_diff[32] ? -dwell_diff : dwell_diff;
    dwell_bad  = (dwell_q == DWELL_MAX) ||
                 (dwell_abs > $signed({1'b0, TOL_CYCLES}));
  end

  // State register and all datapath flops. led_q samples every cycle, even in
  // reset; primed_q marks that led_q holds a post-reset sample, so the value
  // captured during reset is never judged.
  always_ff @(posedge clk) begin
    led_q <= led_d;
    if (rst) begin
      state_q       <= ST_ACQ;
      primed_q      <= 1'b0;
      idx_q         <= '0;
      valid_q       <= 1'b0;
      step_pulse_q  <= 1'b0;
      step_count_q  <= '0;
      dwell_last_q  <= '0;
      dwell_q       <= '0;
      first_dwell_q <= 1'b1;
      seq_err_q     <= 1'b0;
      time_err_q    <= 1'b0;
      onehot_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      primed_q      <= primed_d;
      idx_q         <= idx_d;
      valid_q       <= valid_d;
      step_pulse_q  <= step_pulse_d;
      step_count_q  <= step_count_d;
      dwell_last_q  <= dwell_last_d;
      dwell_q       <= dwell_d;
      first_dwell_q <= first_dwell_d;
      seq_err_q     <= seq_err_d;
      time_err_q    <= time_err_d;
      onehot_err_q  <= onehot_err_d;
    end
  end

  // Next state: any illegal vector drops back to acquisition, any legal
  // vector leaves us (or keeps us) tracking.
  always_comb begin
    state_d = state_q;
    if (primed_q) begin
      state_d = legal ? ST_TRACK : ST_ACQ;
    end
  end

  // Output / datapath: acquisition loads the index without checks, tracking
  // counts the dwell and validates every index change.
  always_comb begin
    led_d         = bus.led_in;
    primed_d      = 1'b1;
    idx_d         = idx_q;
    valid_d       = valid_q;
    step_pulse_d  = 1'b0;
    step_count_d  = step_count_q;
    dwell_last_d  = dwell_last_q;
    dwell_d       = dwell_q;
    first_dwell_d = first_dwell_q;
    seq_err_d     = seq_err_q;
    time_err_d    = time_err_q;
    onehot_err_d  = onehot_err_q;
    if (primed_q) begin
      valid_d = legal;
      if (!legal) begin
        onehot_err_d = 1'b1;
      end else if (state_q == ST_ACQ) begin
        idx_d         = idx_new;
        dwell_d       = 32'd1;
        first_dwell_d = 1'b1;
      end else if (same_idx) begin
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 32'd1;
      end else begin
        step_pulse_d = 1'b1;
        step_count_d = step_count_q + 16'd1;
        idx_d        = idx_new;
        dwell_last_d = dwell_q;
        dwell_d      = 32'd1;
        if (idx_new != idx_succ) seq_err_d = 1'b1;
        // The dwell right after acquisition started mid-position, so skip it.
        if (!first_dwell_q && dwell_bad) time_err_d = 1'b1;
        first_dwell_d = 1'b0;
      end
    end
  end

  assign bus.idx_out    = idx_q;
  assign bus.valid      = valid_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.step_count = step_count_q;
  assign bus.dwell_last = dwell_last_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.time_err   = time_err_q;
  assign bus.onehot_err = onehot_err_q;

endmodule

// File: tb/tb_led_step_decoder.sv
// ---------------------------------------------------------------------------
// tb_led_step_decoder
// Self-checking bench for led_step_decoder with EXPECT_CYCLES=5, TOL_CYCLES=0.
// A run-length reference model follows every cycle; a vector table and
// directed sequences pin down latency, wrap, sequence, timing, one-hot and
// reset behaviour; a randomized stepper with glitches follows.
// ---------------------------------------------------------------------------
module tb_led_step_decoder;

  localparam int    N_LEDS  = 10;
  localparam int    IDX_W   = 4;
  localparam longint EXP_C  = 5;
  localparam longint TOL_C  = 0;
  localparam longint RUN_MAX = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_step_decoder_if #(.N_LEDS(N_LEDS), .IDX_W(IDX_W)) bus ();

  led_step_decoder #(
    .N_LEDS(N_LEDS),
    .IDX_W(IDX_W),
    .EXPECT_CYCLES(5),
    .TOL_CYCLES(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulses_seen = 0;

  // Reference model state: run-length view of the LED stream.
  logic [9:0] pipe[$];
  bit         m_track;
  int         m_idx;
  longint     m_run;
  bit         m_partial;
  bit         m_valid, m_pulse, m_seq, m_time, m_oh;
  int         m_count;
  longint     m_dlast;

  typedef struct {
    logic       r;
    logic [9:0] led;
    logic [3:0] idx;
    logic       valid;
    logic       pulse;
    logic [15:0] count;
    logic [31:0] dlast;
    logic       seq;
    logic       terr;
    logic       oh;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [63:0] packOut(logic [3:0] idx, logic v, logic p,
                                          logic [15:0] c, logic [31:0] d,
                                          logic s, logic t, logic o);
    return {7'd0, idx, v, p, c, d, s, t, o};
  endfunction

  function automatic logic [63:0] dutOut();
    return packOut(bus.idx_out, bus.valid, bus.step_pulse, bus.step_count,
                   bus.dwell_last, bus.seq_err, bus.time_err, bus.onehot_err);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    m_track = 0; m_idx = 0; m_run = 0; m_partial = 1;
    m_valid = 0; m_pulse = 0; m_seq = 0; m_time = 0; m_oh = 0;
    m_count = 0; m_dlast = 0;
    pipe.delete();
  endtask

  task automatic modelEdge(input logic r, input logic [9:0] led);
    logic [9:0] v;
    int idx;
    m_pulse = 0;
    if (r) begin
      modelReset();
      return;
    end
    if (pipe.size() != 0) begin
      v = pipe.pop_front();
      if ($countones(v) != 1) begin
        m_valid = 0;
        m_oh    = 1;
        m_track = 0;
      end else begin
        idx     = $clog2(v);
        m_valid = 1;
        if (!m_track) begin
          m_track = 1; m_idx = idx; m_run = 1; m_partial = 1;
        end else if (idx == m_idx) begin
          m_run = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX;
        end else begin
          m_pulse = 1;
          m_count = (m_count + 1) % 65536;
          m_dlast = m_run;
          if (idx != (m_idx + 1) % N_LEDS) m_seq = 1;
          if (!m_partial && (m_run >= RUN_MAX || m_run > EXP_C + TOL_C ||
                             m_run < EXP_C - TOL_C)) m_time = 1;
          m_idx = idx; m_run = 1; m_partial = 0;
        end
      end
    end
    pipe.push_back(led);
  endtask

  // Drive one cycle of inputs, advance the model and compare after the edge.
  task automatic applyStimulus(input logic r, input logic [9:0] led);
    rst        = r;
    bus.led_in = led;
    @(posedge clk);
    modelEdge(r, led);
    #1;
    if (bus.step_pulse === 1'b1) pulses_seen++;
    checkOutput("model", dutOut(),
                packOut(4'(m_idx), m_valid, m_pulse, 16'(m_count),
                        32'(m_dlast), m_seq, m_time, m_oh));
  endtask

  task automatic holdLed(input int pos, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 10'(1 << pos));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 10'h000);
    applyStimulus(1'b1, 10'h000);
  endtask

  initial begin
    modelReset();
    bus.led_in = '0;

    // Acquire latency, illegal vectors and re-acquire.
    vecs[0]  = '{1'b1, 10'h000, 4'd0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 10'h001, 4'd0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 10'h001, 4'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 10'h001, 4'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 10'h002, 4'd0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 10'h000, 4'd1, 1'b1, 1'b1, 16'd1, 32'd3, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 10'h003, 4'd1, 1'b0, 1'b0, 16'd1, 32'd3, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 10'h020, 4'd1, 1'b0, 1'b0, 16'd1, 32'd3, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 10'h020, 4'd5, 1'b1, 1'b0, 16'd1, 32'd3, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 10'h040, 4'd5, 1'b1, 1'b0, 16'd1, 32'd3, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 10'h040, 4'd6, 1'b1, 1'b1, 16'd2, 32'd2, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].r, vecs[i].led);
      checkOutput($sformatf("vec%0d", i), dutOut(),
                  packOut(vecs[i].idx, vecs[i].valid, vecs[i].pulse,
                          vecs[i].count, vecs[i].dlast, vecs[i].seq,
                          vecs[i].terr, vecs[i].oh));
    end

    // Correct stepper, 25 steps with two wraps.
    doReset();
    pulses_seen = 0;
    for (int p = 0; p < 26; p++) holdLed(p % 10, 5);
    checkOutput("stepper_pulses", 64'(pulses_seen), 64'd25);
    checkOutput("stepper_count", 64'(bus.step_count), 64'd25);
    checkOutput("stepper_dwell", 64'(bus.dwell_last), 64'd5);
    checkOutput("stepper_errs", {61'd0, bus.seq_err, bus.time_err, bus.onehot_err}, 64'd0);

    // Skipped position 3 -> 5.
    doReset();
    for (int p = 0; p < 4; p++) holdLed(p, 5);
    holdLed(5, 2);
    checkOutput("skip_pulse_idx_seq", {58'd0, bus.step_pulse, bus.idx_out, bus.seq_err},
                {58'd0, 1'b1, 4'd5, 1'b1});
    holdLed(5, 3);
    holdLed(6, 5);
    holdLed(7, 5);
    checkOutput("skip_seq_sticky", {62'd0, bus.seq_err, bus.time_err}, {62'd0, 1'b1, 1'b0});

    // Long dwell, then a short dwell right after acquisition.
    doReset();
    holdLed(0, 5); holdLed(1, 5); holdLed(2, 7); holdLed(3, 2);
    checkOutput("long_dwell_last", 64'(bus.dwell_last), 64'd7);
    checkOutput("long_dwell_terr", {62'd0, bus.time_err, bus.seq_err}, {62'd0, 1'b1, 1'b0});
    doReset();
    holdLed(0, 2); holdLed(1, 2);
    checkOutput("short_first_dwell", 64'(bus.dwell_last), 64'd2);
    holdLed(1, 3); holdLed(2, 5); holdLed(3, 2);
    checkOutput("short_first_terr", {31'd0, bus.dwell_last, bus.time_err},
                {31'd0, 32'd5, 1'b0});

    // Mid-dwell reset with every sticky error set.
    doReset();
    holdLed(0, 5); holdLed(1, 5); holdLed(3, 7); holdLed(4, 5);
    applyStimulus(1'b0, 10'h000);
    holdLed(5, 2);
    checkOutput("all_errs_set", {61'd0, bus.seq_err, bus.time_err, bus.onehot_err}, 64'd7);
    applyStimulus(1'b1, 10'h020);
    checkOutput("reset_all_zero", dutOut(), 64'd0);
    holdLed(5, 2);
    checkOutput("reacquire_clean", dutOut(),
                packOut(4'd5, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0));

    // Randomized stepper with skips, jitter, glitches and one reset.
    begin
      int pos;
      int dw;
      logic [9:0] bad;
      doReset();
      pos = 0;
      for (int i = 0; i < 60; i++) begin
        if (i == 30) applyStimulus(1'b1, 10'(1 << pos));
        if ($urandom_range(0, 99) < 8) begin
          bad = ($urandom_range(0, 1) == 0) ? 10'h000 : (10'($urandom) | 10'h003);
          applyStimulus(1'b0, bad);
        end
        if ($urandom_range(0, 99) < 12) pos = $urandom_range(0, 9);
        else pos = (pos + 1) % 10;
        dw = ($urandom_range(0, 9) < 7) ? 5 : $urandom_range(1, 8);
        holdLed(pos, dw);
      end
      holdLed(pos, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
